// File: rtl/inst_decode_ctrl_if.sv
// inst_decode_ctrl_if -- bundle between fetch, the decode controller and
// the execute stage.
//   instr_code  : instruction word from fetch (fetch -> decode)
//   jump/branch : redirect request and target index (decode -> fetch)
//   nop         : stall request, fetch holds PC (decode -> fetch)
//   ex_*        : ID/EX pipeline register fields and control bits
//   illegal_cnt : saturating count of illegal opcodes decoded
// master = fetch/execute side, slave = the decode controller.
interface inst_decode_ctrl_if;
   logic [31:0] instr_code;
   logic        jump;
   logic        nop;
   logic [25:0] branch;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_funct;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_rd;
   logic [31:0] ex_imm;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_alu_src;
   logic        ex_valid;
   logic [7:0]  illegal_cnt;

   modport master (
      output instr_code,
      input  jump, nop, branch,
      input  ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_imm,
      input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_valid,
      input  illegal_cnt
   );

   modport slave (
      input  instr_code,
      output jump, nop, branch,
      output ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_imm,
      output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_valid,
      output illegal_cnt
   );
endinterface

// File: rtl/inst_decode_ctrl.sv
// inst_decode_ctrl -- IF/ID register, instruction decode, load-use hazard
// detection, jump redirect and ID/EX register for a 5-opcode MIPS subset.
// Ports:
//   clk   : rising-edge clock shared with fetch
//   reset : asynchronous, active-low
//   bus   : inst_decode_ctrl_if.slave (instr_code in; jump, nop, branch,
//           ex_* and illegal_cnt out)
module inst_decode_ctrl (
   input  logic                clk,
   input  logic                reset,
   inst_decode_ctrl_if.slave   bus
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic [31:0] ifid;

   // ID/EX register
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_imm;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_valid;
   logic [7:0]  illegal_cnt;

   // decode of the IF/ID word
   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic        is_r, is_lw, is_sw, is_addi, is_j, illegal, is_zero;
   logic        uses_rs, uses_rt, hazard, jump, bubble;

   assign opcode  = ifid[31:26];
   assign rs      = ifid[25:21];
   assign rt      = ifid[20:16];
   assign is_r    = (opcode == OP_R);
   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign is_addi = (opcode == OP_ADDI);
   assign is_j    = (opcode == OP_J);
   assign illegal = !(is_r || is_lw || is_sw || is_addi || is_j);
   assign is_zero = (ifid == 32'h0);

   assign uses_rs = is_r || is_lw || is_sw || is_addi;
   assign uses_rt = is_r || is_sw;

   // Load-use: the load in EX would deliver its rt too late for this word.
   // $0 never carries a dependency. The bubble inserted on a hazard clears
   // ex_valid, so the stall cannot last more than one cycle.
   assign hazard = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                   ((uses_rs && (ex_rt == rs)) || (uses_rt && (ex_rt == rt)));

   // j reads no registers, so hazard and is_j are already exclusive; the
   // gating makes nop's precedence explicit.
   assign jump   = is_j && !hazard;
   assign bubble = hazard || jump || illegal || is_zero;

   // IF/ID: hold on stall, flush the wrong-path fetch on a jump
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      ifid <= 32'h0;
      else if (hazard) ifid <= ifid;
      else if (jump)   ifid <= 32'h0;
      else             ifid <= bus.instr_code;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_opcode    <= '0;
         ex_funct     <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_rd        <= '0;
         ex_imm       <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_valid     <= 1'b0;
      end else if (bubble) begin
         ex_opcode    <= '0;
         ex_funct     <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_rd        <= '0;
         ex_imm       <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_valid     <= 1'b0;
      end else begin
         ex_opcode    <= opcode;
         ex_funct     <= ifid[5:0];
         ex_rs        <= rs;
         ex_rt        <= rt;
         ex_rd        <= ifid[15:11];
         ex_imm       <= {{16{ifid[15]}}, ifid[15:0]};
         ex_reg_write <= is_r || is_lw || is_addi;
         ex_mem_read  <= is_lw;
         ex_mem_write <= is_sw;
         ex_alu_src   <= is_lw || is_sw || is_addi;
         ex_valid     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         illegal_cnt <= 8'h0;
      else if (illegal && !hazard && (illegal_cnt != 8'hFF))
         illegal_cnt <= illegal_cnt + 8'd1;
   end

   assign bus.jump         = jump;
   assign bus.nop          = hazard;
   assign bus.branch       = ifid[25:0];
   assign bus.ex_opcode    = ex_opcode;
   assign bus.ex_funct     = ex_funct;
   assign bus.ex_rs        = ex_rs;
   assign bus.ex_rt        = ex_rt;
   assign bus.ex_rd        = ex_rd;
   assign bus.ex_imm       = ex_imm;
   assign bus.ex_reg_write = ex_reg_write;
   assign bus.ex_mem_read  = ex_mem_read;
   assign bus.ex_mem_write = ex_mem_write;
   assign bus.ex_alu_src   = ex_alu_src;
   assign bus.ex_valid     = ex_valid;
   assign bus.illegal_cnt  = illegal_cnt;

endmodule
